// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, branch flushes, load-use bubbles and a memory timeout trap.
// Optional saturating performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_use_rs1_i,
   input  logic              id_use_rs2_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              ex_mem_read_i,
   input  logic              ex_branch_taken_i,
   input  logic              dmem_req_i,
   input  logic              dmem_ready_i,
   output logic              pc_stall_o,
   output logic              ifid_stall_o,
   output logic              idex_stall_o,
   output logic              exmem_stall_o,
   output logic              ifid_clear_o,
   output logic              idex_clear_o,
   output logic              memwb_clear_o,
   output logic [1:0]        state_o,
   output logic              err_o,
   output logic [31:0]       stall_cnt_o,
   output logic [31:0]       flush_cnt_o
);

   // The wait counter only ever holds 0 .. MEM_TIMEOUT-1.
   localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_e;

   state_e         state_r;
   state_e         state_nxt_s;
   logic [WCW-1:0] wait_cnt_r;
   logic [WCW-1:0] wait_nxt_s;
   logic           err_r;
   logic           err_nxt_s;

   logic           mem_block_s;
   logic           load_use_s;
   logic           hold_all_s;
   logic           issue_s;
   logic           branch_flush_s;

   logic           pc_stall_s;
   logic           ifid_stall_s;
   logic           idex_stall_s;
   logic           exmem_stall_s;
   logic           ifid_clear_s;
   logic           idex_clear_s;
   logic           memwb_clear_s;

   // Raw hazard conditions presented this cycle
   always_comb begin
      mem_block_s = dmem_req_i && !dmem_ready_i;
      load_use_s  = ex_mem_read_i && (ex_rd_i != {REG_AW{1'b0}}) &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
   end

   // Next-state logic; issue_s marks a cycle in which the pipe advances normally
   always_comb begin
      state_nxt_s = state_r;
      wait_nxt_s  = wait_cnt_r;
      err_nxt_s   = err_r;
      hold_all_s  = 1'b0;
      issue_s     = 1'b0;
      case (state_r)
         ST_MEM_WAIT: begin
            if (!dmem_ready_i) begin
               hold_all_s = 1'b1;
               if (wait_cnt_r == WAIT_LAST) begin
                  state_nxt_s = ST_ERR;
                  err_nxt_s   = 1'b1;
               end else begin
                  wait_nxt_s = wait_cnt_r + WCW'(1);
               end
            end else begin
               // Release cycle: held instructions re-present their events now.
               state_nxt_s = ST_RUN;
               issue_s     = 1'b1;
            end
         end
         ST_ERR: begin
            hold_all_s = 1'b1;
            err_nxt_s  = 1'b1;
         end
         default: begin
            state_nxt_s = ST_RUN;
            if (mem_block_s) begin
               hold_all_s  = 1'b1;
               state_nxt_s = ST_MEM_WAIT;
               wait_nxt_s  = {WCW{1'b0}};
            end else begin
               issue_s = 1'b1;
            end
         end
      endcase
   end

   // Stall / clear decode with reset override and fixed event priority
   always_comb begin
      pc_stall_s     = 1'b0;
      ifid_stall_s   = 1'b0;
      idex_stall_s   = 1'b0;
      exmem_stall_s  = 1'b0;
      ifid_clear_s   = 1'b0;
      idex_clear_s   = 1'b0;
      memwb_clear_s  = 1'b0;
      branch_flush_s = 1'b0;
      if (rst_i) begin
         ifid_clear_s  = 1'b1;
         idex_clear_s  = 1'b1;
         memwb_clear_s = 1'b1;
      end else if (hold_all_s) begin
         pc_stall_s    = 1'b1;
         ifid_stall_s  = 1'b1;
         idex_stall_s  = 1'b1;
         exmem_stall_s = 1'b1;
         memwb_clear_s = 1'b1;
      end else if (issue_s && ex_branch_taken_i) begin
         ifid_clear_s   = 1'b1;
         idex_clear_s   = 1'b1;
         branch_flush_s = 1'b1;
      end else if (issue_s && load_use_s) begin
         pc_stall_s   = 1'b1;
         ifid_stall_s = 1'b1;
         idex_clear_s = 1'b1;
      end else begin
         branch_flush_s = 1'b0;
      end
   end

   // State register, wait counter and sticky error flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= ST_RUN;
         wait_cnt_r <= {WCW{1'b0}};
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_nxt_s;
         err_r      <= err_nxt_s;
      end
   end

   // Present the current state; the unused encoding reads as RUN
   always_comb begin
      case (state_r)
         ST_MEM_WAIT: state_o = 2'd1;
         ST_ERR:      state_o = 2'd2;
         default:     state_o = 2'd0;
      endcase
   end

   assign pc_stall_o    = pc_stall_s;
   assign ifid_stall_o  = ifid_stall_s;
   assign idex_stall_o  = idex_stall_s;
   assign exmem_stall_o = exmem_stall_s;
   assign ifid_clear_o  = ifid_clear_s;
   assign idex_clear_o  = idex_clear_s;
   assign memwb_clear_o = memwb_clear_s;
   assign err_o         = err_r;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] flush_cnt_r;

   // Saturating stall and branch-flush counters
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         if (pc_stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (branch_flush_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
            flush_cnt_r <= flush_cnt_r + 32'd1;
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_r;
   assign flush_cnt_o = flush_cnt_r;
`else
   assign stall_cnt_o = 32'd0;
   assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_hazard_ctrl;
   localparam int AW = 5;
   localparam int TO = 4;

   localparam logic [6:0] O_IDLE = 7'b0000_000;
   localparam logic [6:0] O_HOLD = 7'b1111_001;
   localparam logic [6:0] O_BR   = 7'b0000_110;
   localparam logic [6:0] O_LU   = 7'b1100_010;
   localparam logic [6:0] O_RST  = 7'b0000_111;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0;
   logic          use1 = 1'b0, use2 = 1'b0, mrd = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
   logic          pc_stall, ifid_stall, idex_stall, exmem_stall;
   logic          ifid_clear, idex_clear, memwb_clear, err;
   logic [1:0]    state;
   logic [31:0]   scnt, fcnt;
   logic [6:0]    outs;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: plain bookkeeping of the memory wait and error trap
   bit          m_wait = 1'b0;
   bit          m_err  = 1'b0;
   int          m_wcnt = 0;
   logic [31:0] m_stalls = 32'd0;
   logic [31:0] m_flushes = 32'd0;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
      .ex_rd_i(rd), .ex_mem_read_i(mrd), .ex_branch_taken_i(br),
      .dmem_req_i(req), .dmem_ready_i(rdy),
      .pc_stall_o(pc_stall), .ifid_stall_o(ifid_stall), .idex_stall_o(idex_stall),
      .exmem_stall_o(exmem_stall), .ifid_clear_o(ifid_clear), .idex_clear_o(idex_clear),
      .memwb_clear_o(memwb_clear), .state_o(state), .err_o(err),
      .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
   );

   assign outs = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_clear, idex_clear, memwb_clear};

   function automatic logic [6:0] exp_outs();
      bit lu;
      lu = mrd && (rd != '0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
      if (rst) return O_RST;
      if (m_err) return O_HOLD;
      if (m_wait ? !rdy : (req && !rdy)) return O_HOLD;
      if (br) return O_BR;
      if (lu) return O_LU;
      return O_IDLE;
   endfunction

   function automatic logic [1:0] exp_state();
      return m_err ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
   endfunction

   function automatic logic [31:0] exp_scnt();
`ifdef HAZARD_PERF_CNT_EN
      return m_stalls;
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] exp_fcnt();
`ifdef HAZARD_PERF_CNT_EN
      return m_flushes;
`else
      return 32'd0;
`endif
   endfunction

   // Advance one clock and update the model with the inputs seen at that edge
   task automatic tick();
      logic [6:0] e;
      @(posedge clk);
      e = exp_outs();
      if (rst) begin
         m_wait = 1'b0; m_err = 1'b0; m_wcnt = 0; m_stalls = 32'd0; m_flushes = 32'd0;
      end else begin
         if (e[6] && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
         if (e == O_BR && m_flushes != 32'hFFFF_FFFF) m_flushes = m_flushes + 32'd1;
         if (!m_err) begin
            if (m_wait) begin
               if (!rdy) begin
                  m_wcnt = m_wcnt + 1;
                  if (m_wcnt >= TO) begin m_err = 1'b1; m_wait = 1'b0; end
               end else begin
                  m_wait = 1'b0;
               end
            end else if (req && !rdy) begin
               m_wait = 1'b1; m_wcnt = 0;
            end
         end
      end
      #1;
   endtask

   task automatic set_idle();
      rst = 1'b0; rs1 = '0; rs2 = '0; rd = '0; use1 = 1'b0; use2 = 1'b0;
      mrd = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      set_idle();
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b1; rdy = 1'b0; br = 1'b1; mrd = 1'b1; rd = 5'd3; rs1 = 5'd3; use1 = 1'b1;
      @(negedge clk);
      n_checks++; if (outs !== O_RST) $display("FAIL reset_outs: got %b expected %b", outs, O_RST); else n_pass++;
      tick();
      set_idle();
      @(negedge clk);
      n_checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
      n_checks++; if (outs !== O_IDLE) $display("FAIL reset_idle_outs: got %b expected %b", outs, O_IDLE); else n_pass++;
      n_checks++; if (scnt !== 32'd0 || fcnt !== 32'd0) $display("FAIL reset_cnts: got %0d/%0d expected 0/0", scnt, fcnt); else n_pass++;
      tick();
   endtask

   task automatic test_load_use();
      set_idle(); mrd = 1'b1; rd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
      @(negedge clk);
      n_checks++; if (outs !== O_LU) $display("FAIL lu_rs1: got %b expected %b", outs, O_LU); else n_pass++;
      tick();
      mrd = 1'b0;
      @(negedge clk);
      n_checks++; if (outs !== O_IDLE) $display("FAIL lu_release: got %b expected %b", outs, O_IDLE); else n_pass++;
      tick();
      mrd = 1'b1; rd = 5'd0; rs1 = 5'd0;
      @(negedge clk);
      n_checks++; if (outs !== O_IDLE) $display("FAIL lu_x0: got %b expected %b", outs, O_IDLE); else n_pass++;
      tick();
      rd = 5'd7; rs1 = 5'd2; rs2 = 5'd7; use1 = 1'b1; use2 = 1'b1;
      @(negedge clk);
      n_checks++; if (outs !== O_LU) $display("FAIL lu_rs2: got %b expected %b", outs, O_LU); else n_pass++;
      tick();
      use2 = 1'b0;
      @(negedge clk);
      n_checks++; if (outs !== O_IDLE) $display("FAIL lu_unused_src: got %b expected %b", outs, O_IDLE); else n_pass++;
      tick();
   endtask

   task automatic test_branch();
      logic [31:0] want;
      do_reset();
      br = 1'b1;
      @(negedge clk);
      n_checks++; if (outs !== O_BR) $display("FAIL br_flush: got %b expected %b", outs, O_BR); else n_pass++;
      tick();
      br = 1'b0;
      @(negedge clk);
      n_checks++; if (outs !== O_IDLE) $display("FAIL br_one_cycle: got %b expected %b", outs, O_IDLE); else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
      want = 32'd1;
`else
      want = 32'd0;
`endif
      n_checks++; if (fcnt !== want) $display("FAIL br_flush_cnt: got %0d expected %0d", fcnt, want); else n_pass++;
      tick();
   endtask

   task automatic test_mem_wait();
      logic [31:0] want;
      do_reset();
      req = 1'b1; rdy = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         n_checks++; if (outs !== O_HOLD) $display("FAIL mw_hold_c%0d: got %b expected %b", c, outs, O_HOLD); else n_pass++;
         n_checks++; if (state !== ((c == 1) ? 2'd0 : 2'd1)) $display("FAIL mw_state_c%0d: got %0d", c, state); else n_pass++;
         tick();
      end
      rdy = 1'b1;
      @(negedge clk);
      n_checks++; if (outs !== O_IDLE) $display("FAIL mw_ready_release: got %b expected %b", outs, O_IDLE); else n_pass++;
      tick();
      req = 1'b0; rdy = 1'b0;
      @(negedge clk);
      n_checks++; if (state !== 2'd0) $display("FAIL mw_back_to_run: got %0d expected 0", state); else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
      want = 32'd3;
`else
      want = 32'd0;
`endif
      n_checks++; if (scnt !== want) $display("FAIL mw_stall_cnt: got %0d expected %0d", scnt, want); else n_pass++;
      n_checks++; if (fcnt !== 32'd0) $display("FAIL mw_flush_cnt: got %0d expected 0", fcnt); else n_pass++;
      tick();
   endtask

   task automatic test_simultaneous();
      set_idle();
      req = 1'b1; rdy = 1'b0; br = 1'b1; mrd = 1'b1; rd = 5'd9; rs1 = 5'd9; use1 = 1'b1;
      @(negedge clk);
      n_checks++; if (outs !== O_HOLD) $display("FAIL sim_mem_wins: got %b expected %b", outs, O_HOLD); else n_pass++;
      tick();
      rdy = 1'b1;
      @(negedge clk);
      n_checks++; if (outs !== O_BR) $display("FAIL sim_branch_on_release: got %b expected %b", outs, O_BR); else n_pass++;
      tick();
      set_idle();
      @(negedge clk);
      n_checks++; if (state !== 2'd0 || outs !== O_IDLE) $display("FAIL sim_after: got state %0d outs %b expected 0 %b", state, outs, O_IDLE); else n_pass++;
      n_checks++; if (fcnt !== exp_fcnt()) $display("FAIL sim_flush_cnt: got %0d expected %0d", fcnt, exp_fcnt()); else n_pass++;
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      req = 1'b1; rdy = 1'b0;
      for (int c = 0; c <= TO; c++) begin
         @(negedge clk);
         n_checks++; if (outs !== O_HOLD) $display("FAIL to_hold_c%0d: got %b expected %b", c, outs, O_HOLD); else n_pass++;
         n_checks++; if (state !== ((c == 0) ? 2'd0 : 2'd1) || err !== 1'b0) $display("FAIL to_wait_c%0d: got state %0d err %b", c, state, err); else n_pass++;
         tick();
      end
      rdy = 1'b1; req = 1'b0;
      @(negedge clk);
      n_checks++; if (state !== 2'd2 || err !== 1'b1) $display("FAIL to_err: got state %0d err %b expected 2 1", state, err); else n_pass++;
      n_checks++; if (outs !== O_HOLD) $display("FAIL to_err_hold: got %b expected %b", outs, O_HOLD); else n_pass++;
      tick();
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (outs !== O_RST) $display("FAIL to_rst_outs: got %b expected %b", outs, O_RST); else n_pass++;
      tick();
      set_idle();
      @(negedge clk);
      n_checks++; if (state !== 2'd0 || err !== 1'b0 || outs !== O_IDLE) $display("FAIL to_recover: got state %0d err %b outs %b", state, err, outs); else n_pass++;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst  = ($urandom_range(0, 59) == 32'd0);
         req  = ($urandom_range(0, 3) == 32'd0);
         rdy  = ($urandom_range(0, 2) == 32'd0);
         br   = ($urandom_range(0, 5) == 32'd0);
         mrd  = 1'($urandom_range(0, 1));
         rd   = AW'($urandom_range(0, 3));
         rs1  = AW'($urandom_range(0, 3));
         rs2  = AW'($urandom_range(0, 3));
         use1 = 1'($urandom_range(0, 1));
         use2 = 1'($urandom_range(0, 1));
         @(negedge clk);
         n_checks++; if (outs !== exp_outs()) $display("FAIL rnd_outs@%0d: got %b expected %b", i, outs, exp_outs()); else n_pass++;
         n_checks++; if (state !== exp_state()) $display("FAIL rnd_state@%0d: got %0d expected %0d", i, state, exp_state()); else n_pass++;
         n_checks++; if (err !== m_err) $display("FAIL rnd_err@%0d: got %b expected %b", i, err, m_err); else n_pass++;
         n_checks++; if (scnt !== exp_scnt()) $display("FAIL rnd_stall_cnt@%0d: got %0d expected %0d", i, scnt, exp_scnt()); else n_pass++;
         n_checks++; if (fcnt !== exp_fcnt()) $display("FAIL rnd_flush_cnt@%0d: got %0d expected %0d", i, fcnt, exp_fcnt()); else n_pass++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_simultaneous();
      test_timeout();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum MEM_WAIT cycles before error (>=1).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports id_rs1_i, id_rs2_i  input  REG_AW  source registers of the instruction in ID.
REQ-006 SHALL have ports id_use_rs1_i, id_use_rs2_i  input  1  ID instruction reads rs1/rs2.
REQ-007 SHALL have port ex_rd_i  input  REG_AW  destination register of the instruction in EX.
REQ-008 SHALL have port ex_mem_read_i  input  1  EX instruction is a load.
REQ-009 SHALL have port ex_branch_taken_i  input  1  branch/jump in EX resolved taken.
REQ-010 SHALL have ports dmem_req_i, dmem_ready_i  input  1  MEM-stage access request / completion.
REQ-011 SHALL have outputs pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o  output  1  hold PC / pipe register.
REQ-012 SHALL have outputs ifid_clear_o, idex_clear_o, memwb_clear_o  output  1  zero pipe register (bubble).
REQ-013 SHALL have outputs state_o  output  2  current state; err_o  output  1  sticky memory-timeout flag.
REQ-014 SHALL have outputs stall_cnt_o, flush_cnt_o  output  32  performance counters.

Function
REQ-015 SHALL implement states RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2; 2'd3 unreachable and SHALL decode as RUN.
REQ-016 SHALL drive all stall/clear outputs combinationally from the current state and inputs (zero added latency).
REQ-017 SHALL define mem_block = dmem_req_i && !dmem_ready_i.
REQ-018 SHALL define load_use = ex_mem_read_i && ex_rd_i!=0 && ((id_use_rs1_i && id_rs1_i==ex_rd_i) || (id_use_rs2_i && id_rs2_i==ex_rd_i)).
REQ-019 SHALL apply priority mem_block/MEM_WAIT > ex_branch_taken_i > load_use; at most one action per cycle.
REQ-020 SHALL, in RUN with mem_block, assert pc/ifid/idex/exmem stall and memwb_clear, and go to MEM_WAIT next cycle.
REQ-021 SHALL, in MEM_WAIT, assert the same outputs while dmem_ready_i=0; on dmem_ready_i=1 deassert all of them that cycle and return to RUN.
REQ-022 SHALL, in RUN with ex_branch_taken_i and no mem_block, assert ifid_clear_o and idex_clear_o for exactly that cycle, no stalls.
REQ-023 SHALL, in RUN with load_use and neither higher event, assert pc_stall_o, ifid_stall_o and idex_clear_o for that cycle only.
REQ-024 SHALL ignore ex_branch_taken_i and load_use while stalled; held instructions re-present them on release.
REQ-025 SHALL count MEM_WAIT cycles in a wait counter cleared on entry; when it reaches MEM_TIMEOUT with dmem_ready_i=0, go to ERR and set err_o.
REQ-026 SHALL, in ERR, hold all stall outputs asserted and memwb_clear_o=1 until reset; err_o remains 1.
REQ-027 SHALL keep all outputs 0 in RUN with no event.

Reset
REQ-028 SHALL, on a clock edge with rst_i=1, enter RUN, clear the wait counter, err_o, stall_cnt_o and flush_cnt_o.
REQ-029 SHALL, while rst_i=1, drive all stall outputs 0 and ifid_clear_o, idex_clear_o, memwb_clear_o 1.
REQ-030 SHALL, on reset asserted in MEM_WAIT or ERR, be in RUN the following cycle, with no residual stall.

Configuration
REQ-031 SHALL, with macro HAZARD_PERF_CNT_EN defined, increment stall_cnt_o each cycle pc_stall_o=1 and flush_cnt_o each branch flush cycle, both saturating at 32'hFFFFFFFF.
REQ-032 SHALL, without HAZARD_PERF_CNT_EN, keep both counter ports present and tied to 0, with no counter flops.

Verification
REQ-033 Load-use: ex_mem_read_i=1, ex_rd_i=5, id_rs1_i=5, id_use_rs1_i=1 -> pc_stall_o=ifid_stall_o=idex_clear_o=1 for one cycle; with ex_rd_i=0 -> no stall.
REQ-034 Branch: ex_branch_taken_i=1 for one cycle -> ifid_clear_o=idex_clear_o=1 that cycle; flush_cnt_o=1 (macro on).
REQ-035 Memory wait: dmem_req_i=1, dmem_ready_i=0 for 3 cycles then 1 -> four-stage stall for 3 cycles, state_o=1 for cycles 2-3, RUN after ready; stall_cnt_o=3.
REQ-036 Simultaneous: mem_block, branch and load_use same cycle -> only memory stall; branch flush occurs in the cycle dmem_ready_i=1 is followed by unstalled issue.
REQ-037 Timeout: MEM_TIMEOUT=4, dmem_ready_i held 0 -> state_o=2, err_o=1 after 4 MEM_WAIT cycles; rst_i=1 one cycle -> state_o=0, err_o=0.
REQ-038 Counters without HAZARD_PERF_CNT_EN: repeat REQ-035 -> stall_cnt_o=flush_cnt_o=0.
